// File: rtl/debounce_bank.sv
// debounce_bank: per-channel synchroniser + hold-time debounce, level/rising/falling outputs, sticky pending flags (clear/edge enables) and OR-ed irq
module debounce_bank #(
  parameter int CHANNELS = 8,
  parameter int HOLD_COUNT = 31,
  parameter int SYNC_STAGES = 2,
  parameter logic [CHANNELS-1:0] RESET_LEVEL = {CHANNELS{1'b0}}
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] signal_in,
  input  logic [CHANNELS-1:0] rise_en,
  input  logic [CHANNELS-1:0] fall_en,
  input  logic [CHANNELS-1:0] event_clear,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rising,
  output logic [CHANNELS-1:0] falling,
  output logic [CHANNELS-1:0] pending,
  output logic                irq
);
  localparam int CW = $clog2(HOLD_COUNT + 1);
  localparam logic [CW-1:0] LAST = CW'(HOLD_COUNT - 1);
  logic [SYNC_STAGES*CHANNELS-1:0] chain;
  logic [CHANNELS-1:0] s;
  logic [CW-1:0] cnt [CHANNELS];
  assign s = chain[SYNC_STAGES*CHANNELS-1 -: CHANNELS];
  assign irq = |pending;
  always_ff @(posedge clk)
    chain <= reset ? {SYNC_STAGES{RESET_LEVEL}} : {chain[(SYNC_STAGES-1)*CHANNELS-1:0], signal_in};
  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (reset) begin
        cnt[c] <= '0;
        level[c] <= RESET_LEVEL[c];
        rising[c] <= 1'b0;
        falling[c] <= 1'b0;
        pending[c] <= 1'b0;
      end else begin
        rising[c] <= 1'b0;
        falling[c] <= 1'b0;
        if (s[c] == level[c]) cnt[c] <= '0;
        else if (cnt[c] == LAST) begin
          cnt[c] <= '0;
          level[c] <= s[c];
          rising[c] <= s[c];
          falling[c] <= ~s[c];
        end else cnt[c] <= cnt[c] + CW'(1);
        pending[c] <= (rising[c] & rise_en[c]) | (falling[c] & fall_en[c]) | (pending[c] & ~event_clear[c]);
      end
    end
  end
endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: directed scenario tasks for debounce_bank with CHANNELS=4, HOLD_COUNT=4, SYNC_STAGES=2
module tb_debounce_bank;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] signal_in, rise_en, fall_en, event_clear;
  logic [3:0] level, rising, falling, pending;
  logic irq;
  logic [3:0] seen;
  int errors = 0;
  int checks = 0;
  debounce_bank #(.CHANNELS(4), .HOLD_COUNT(4), .SYNC_STAGES(2), .RESET_LEVEL(4'b0000)) dut (
    .clk(clk), .reset(reset), .signal_in(signal_in), .rise_en(rise_en), .fall_en(fall_en),
    .event_clear(event_clear), .level(level), .rising(rising), .falling(falling),
    .pending(pending), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      seen = seen | rising | falling;
    end
  endtask
  task automatic test_reset;
    reset = 1'b1;
    step(2);
    checks++; if (level !== 4'b0000) begin errors++; $display("FAIL reset_level got=%b exp=0000", level); end
    checks++; if ({rising, falling} !== 8'h00) begin errors++; $display("FAIL reset_pulses got=%b exp=00000000", {rising, falling}); end
    checks++; if (pending !== 4'b0000 || irq !== 1'b0) begin errors++; $display("FAIL reset_pending got=%b/%b exp=0000/0", pending, irq); end
    reset = 1'b0;
  endtask
  task automatic test_press;
    seen = '0;
    signal_in = 4'b0001;
    step(5);
    checks++; if (level !== 4'b0000 || seen !== 4'b0000) begin errors++; $display("FAIL press_early got=%b/%b exp=0000/0000", level, seen); end
    step(1);
    checks++; if (level !== 4'b0001) begin errors++; $display("FAIL press_level got=%b exp=0001", level); end
    checks++; if (rising !== 4'b0001 || falling !== 4'b0000) begin errors++; $display("FAIL press_pulse got=%b/%b exp=0001/0000", rising, falling); end
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL press_pending_early got=%b exp=0000", pending); end
    step(1);
    checks++; if (rising !== 4'b0000) begin errors++; $display("FAIL press_one_cycle got=%b exp=0000", rising); end
    checks++; if (pending !== 4'b0001 || irq !== 1'b1) begin errors++; $display("FAIL press_pending got=%b/%b exp=0001/1", pending, irq); end
    event_clear = 4'b1111;
    step(1);
    event_clear = 4'b0000;
    checks++; if (pending !== 4'b0000 || irq !== 1'b0) begin errors++; $display("FAIL press_clear got=%b/%b exp=0000/0", pending, irq); end
  endtask
  task automatic test_glitch;
    seen = '0;
    signal_in = 4'b0011;
    step(3);
    signal_in = 4'b0001;
    step(6);
    checks++; if (level !== 4'b0001 || seen !== 4'b0000) begin errors++; $display("FAIL glitch_reject got=%b/%b exp=0001/0000", level, seen); end
    signal_in = 4'b0011;
    step(5);
    checks++; if (level !== 4'b0001) begin errors++; $display("FAIL glitch_hold_early got=%b exp=0001", level); end
    step(1);
    checks++; if (level !== 4'b0011 || rising !== 4'b0010) begin errors++; $display("FAIL glitch_hold got=%b/%b exp=0011/0010", level, rising); end
    step(1);
    checks++; if (pending !== 4'b0010) begin errors++; $display("FAIL glitch_pending got=%b exp=0010", pending); end
    event_clear = 4'b1111;
    step(1);
    event_clear = 4'b0000;
  endtask
  task automatic test_enables;
    rise_en = 4'b1011;
    signal_in = 4'b0111;
    step(6);
    checks++; if (rising !== 4'b0100 || level !== 4'b0111) begin errors++; $display("FAIL en_rise_pulse got=%b/%b exp=0100/0111", rising, level); end
    step(1);
    checks++; if (pending !== 4'b0000 || irq !== 1'b0) begin errors++; $display("FAIL en_rise_masked got=%b/%b exp=0000/0", pending, irq); end
    signal_in = 4'b0011;
    step(6);
    checks++; if (falling !== 4'b0100 || rising !== 4'b0000 || level !== 4'b0011) begin errors++; $display("FAIL en_fall_pulse got=%b/%b/%b exp=0100/0000/0011", falling, rising, level); end
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL en_fall_early got=%b exp=0000", pending); end
    step(1);
    checks++; if (pending !== 4'b0100 || irq !== 1'b1) begin errors++; $display("FAIL en_fall_pending got=%b/%b exp=0100/1", pending, irq); end
    rise_en = 4'b1111;
    step(1);
    checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL en_no_clear got=%b exp=0100", pending); end
    event_clear = 4'b0100;
    step(1);
    event_clear = 4'b0000;
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL en_clear got=%b exp=0000", pending); end
  endtask
  task automatic test_clear_race;
    event_clear = 4'b1000;
    signal_in = 4'b1011;
    step(6);
    checks++; if (rising !== 4'b1000) begin errors++; $display("FAIL race_pulse got=%b exp=1000", rising); end
    step(1);
    checks++; if (pending !== 4'b1000 || irq !== 1'b1) begin errors++; $display("FAIL race_set_wins got=%b/%b exp=1000/1", pending, irq); end
    event_clear = 4'b0000;
    step(1);
    checks++; if (pending !== 4'b1000) begin errors++; $display("FAIL race_hold got=%b exp=1000", pending); end
    event_clear = 4'b1000;
    step(1);
    event_clear = 4'b0000;
    checks++; if (pending !== 4'b0000 || irq !== 1'b0) begin errors++; $display("FAIL race_clear got=%b/%b exp=0000/0", pending, irq); end
  endtask
  task automatic test_reset_mid;
    signal_in = 4'b0000;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    checks++; if (level !== 4'b0000 || {rising, falling} !== 8'h00) begin errors++; $display("FAIL mid_prereset got=%b/%b exp=0000/00000000", level, {rising, falling}); end
    step(1);
    seen = '0;
    signal_in = 4'b1111;
    step(3);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(5);
    checks++; if (level !== 4'b0000 || seen !== 4'b0000) begin errors++; $display("FAIL mid_no_pulse got=%b/%b exp=0000/0000", level, seen); end
    step(1);
    checks++; if (rising !== 4'b1111 || level !== 4'b1111) begin errors++; $display("FAIL mid_all_rise got=%b/%b exp=1111/1111", rising, level); end
    step(1);
    checks++; if (pending !== 4'b1111 || irq !== 1'b1 || rising !== 4'b0000) begin errors++; $display("FAIL mid_pending got=%b/%b/%b exp=1111/1/0000", pending, irq, rising); end
  endtask
  initial begin
    reset = 1'b1;
    signal_in = 4'b0000;
    rise_en = 4'b1111;
    fall_en = 4'b1111;
    event_clear = 4'b0000;
    seen = '0;
    test_reset;
    test_press;
    test_glitch;
    test_enables;
    test_clear_race;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
